// File: rtl/decoder_seq_pkg.sv
// Shared definitions for decoder_seq: FSM state encodings and mode-bit positions.
package decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEVEL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned MODE_THERM = 0;
  localparam int unsigned MODE_PULSE = 1;
  localparam int unsigned MODE_W     = 2;

endpackage

// File: rtl/decoder_seq_core.sv
// Combinational code-to-vector decode (one-hot or thermometer) with range check.
module decoder_core #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  code,
  input  logic             therm,
  output logic [OUT_W-1:0] vec,
  output logic             in_range
);

  always_comb begin
    vec = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      vec[i] = therm ? (i <= 32'(code)) : (i == 32'(code));
    end
    in_range = 32'(code) < OUT_W;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered N-to-OUT_W decoder with valid/ready input, level/pulse hold and
// one-hot/thermometer encoding.
module decoder_seq
  import decoder_seq_pkg::*;
#(
  parameter int unsigned IN_W     = 3,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned ACT_LOW  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  input  logic             mode_therm,
  input  logic             mode_pulse,
  output logic [OUT_W-1:0] out_vec,
  output logic             out_valid,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYC + 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [OUT_W-1:0]    vec_q;
  logic [OUT_W-1:0]    dec_vec;
  logic                dec_ok;
  logic [MODE_W-1:0]   mode;
  logic                accept;

  assign mode = {mode_pulse, mode_therm};

  decoder_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .code     (in_code),
    .therm    (mode[MODE_THERM]),
    .vec      (dec_vec),
    .in_range (dec_ok)
  );

  assign in_ready = rst_n && (state != HOLD);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      vec_q <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        // Out-of-range codes consume the handshake but leave everything else untouched.
        if (!dec_ok) begin
          err <= 1'b1;
        end else begin
          vec_q <= dec_vec;
          if (mode[MODE_PULSE]) begin
            state <= HOLD;
            cnt   <= CNT_W'(HOLD_CYC - 1);
          end else begin
            state <= LEVEL;
            cnt   <= '0;
          end
        end
      end else if (state == HOLD) begin
        if (cnt == '0) begin
          state <= IDLE;
          vec_q <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // vec_q is kept active-high; polarity is applied only at the port.
  assign out_vec   = (ACT_LOW != 0) ? ~vec_q : vec_q;
  assign out_valid = (state != IDLE);

endmodule
